// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte loader.
package loader_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    BYTES,
    WRITE,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in + instruction-memory write port out.
// The slave modport is the loader side, the master modport is the host/memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport slave  (input  s_data, s_valid,
                  output s_ready, imem_we, imem_waddr, imem_wdata);
  modport master (output s_data, s_valid,
                  input  s_ready, imem_we, imem_waddr, imem_wdata);
endinterface

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler. o_word_next is the word including the
// byte presented this cycle, so the caller can capture a completed word on the
// same edge that accepts its last byte.
module byte_to_word
  import loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic [7:0]                  i_byte,
  output logic [8*BYTES_PER_WORD-1:0] o_word_next,
  output logic                        o_word_valid
);
  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0]            r_idx;
  logic [8*BYTES_PER_WORD-1:0] r_word;

  // Insert the incoming byte at the current lane.
  always_comb begin
    o_word_next = r_word;
    o_word_next[8*r_idx +: 8] = i_byte;
  end

  assign o_word_valid = i_en && (r_idx == IDX_W'(BYTES_PER_WORD - 1));

  // Byte lane index and partial word; the index wraps after the last lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_en) begin
      r_word <= o_word_next;
      r_idx  <= r_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a 16-bit little-endian word count, then writes that
// many little-endian 32-bit words to instruction memory from address 0.
//
// state  | meaning
// IDLE   | waiting for load_req
// LEN_LO | accepting word-count low byte
// LEN_HI | accepting word-count high byte, validating count
// BYTES  | accepting the 4 bytes of one instruction
// WRITE  | one-cycle memory write of the assembled word
// DONE   | finished (done or err held) until load_req/abort
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic             abort,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_written
);
  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

  state_t            r_state, w_next;
  logic              r_s_ready, r_busy, r_we, r_done, r_err;
  logic [CNT_W-1:0]  r_count, r_words;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              w_accept, w_start, w_set_done, w_set_err;
  logic              w_b2w_en, w_b2w_clr, w_word_valid;
  logic [31:0]       w_word_next;
  logic [CNT_W-1:0]  w_count_full;

  assign w_accept     = bus.s_valid && r_s_ready;
  assign w_start      = load_req && ((r_state == IDLE) || (r_state == DONE));
  assign w_count_full = {bus.s_data, r_count[7:0]};
  assign w_b2w_en     = w_accept && (r_state == BYTES) && !abort;
  assign w_b2w_clr    = abort || w_start;

  byte_to_word u_b2w (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_b2w_clr),
    .i_en         (w_b2w_en),
    .i_byte       (bus.s_data),
    .o_word_next  (w_word_next),
    .o_word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; abort overrides everything.
  always_comb begin
    w_next     = r_state;
    w_set_done = 1'b0;
    w_set_err  = 1'b0;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (load_req) w_next = LEN_LO;
        LEN_LO:     if (w_accept) w_next = LEN_HI;
        LEN_HI: begin
          if (w_accept) begin
            if (w_count_full == '0) begin
              w_next     = DONE;
              w_set_done = 1'b1;
            end else if (w_count_full > L_DEPTH) begin
              w_next    = DONE;
              w_set_err = 1'b1;
            end else begin
              w_next = BYTES;
            end
          end
        end
        BYTES: if (w_word_valid) w_next = WRITE;
        WRITE: begin
          if ((r_words + CNT_W'(1)) == r_count) begin
            w_next     = DONE;
            w_set_done = 1'b1;
          end else begin
            w_next = BYTES;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Registered strobes decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
    end else begin
      r_s_ready <= (w_next == LEN_LO) || (w_next == LEN_HI) || (w_next == BYTES);
      r_busy    <= (w_next == LEN_LO) || (w_next == LEN_HI) ||
                   (w_next == BYTES)  || (w_next == WRITE);
      r_we      <= (w_next == WRITE);
    end
  end

  // Count header, write address/data capture, progress and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_words <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (abort) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_start) begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_words <= '0;
      r_waddr <= '0;
    end else begin
      if (w_set_done) r_done <= 1'b1;
      if (w_set_err)  r_err  <= 1'b1;
      if ((r_state == LEN_LO) && w_accept) r_count[7:0]  <= bus.s_data;
      if ((r_state == LEN_HI) && w_accept) r_count[15:8] <= bus.s_data;
      if (w_word_valid) begin
        r_waddr <= ADDR_W'(r_words);
        r_wdata <= w_word_next;
      end
      if (r_state == WRITE) r_words <= r_words + CNT_W'(1);
    end
  end

  // Abort kills a write that is already on the bus this cycle.
  assign bus.imem_we    = r_we && !abort;
  assign bus.imem_waddr = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign bus.s_ready    = r_s_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
  assign words_written  = r_words;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [15:0] words_written;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          acc_cnt = 0;
  int          rdy_in_wr = 0;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(.DEPTH(1024), .ADDR_W(32), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_req      (load_req),
    .abort         (abort),
    .bus           (bus.slave),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: logs writes and handshakes that will occur at the next edge.
  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr_q.push_back(bus.imem_waddr);
      wr_data_q.push_back(bus.imem_wdata);
    end
    if (bus.s_valid && bus.s_ready && rst_n && !abort) acc_cnt++;
    if (bus.imem_we && bus.s_ready) rdy_in_wr++;
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    acc_cnt   = 0;
    rdy_in_wr = 0;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      t++;
      if (t > 50) begin
        checks++; errors++;
        $display("FAIL send_byte_timeout: byte %h got no s_ready within 50 cycles", b);
        break;
      end
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.s_ready, bus.imem_we, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {bus.s_ready, bus.imem_we, busy, done, err});
    end
    checks++;
    if (words_written !== 16'd0) begin
      errors++; $display("FAIL reset_words: got %0d expected 0", words_written);
    end
    checks++;
    if (bus.imem_waddr !== 32'd0 || bus.imem_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_bus: got %h/%h expected 0/0", bus.imem_waddr, bus.imem_wdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    logic [7:0] stream[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    clear_log();
    pulse_load();
    checks++;
    if (busy !== 1'b1 || bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL normal_start: busy=%b s_ready=%b expected 1/1", busy, bus.s_ready);
    end
    for (int i = 0; i < 10; i++) send_byte(stream[i], 0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (wr_addr_q.size() !== 2) begin
      errors++; $display("FAIL normal_nwrites: got %0d expected 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'd0 || wr_data_q[0] !== 32'h00100513) begin
        errors++; $display("FAIL normal_w0: got %h@%0d expected 00100513@0", wr_data_q[0], wr_addr_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 32'd1 || wr_data_q[1] !== 32'h00200593) begin
        errors++; $display("FAIL normal_w1: got %h@%0d expected 00200593@1", wr_data_q[1], wr_addr_q[1]);
      end
    end
    checks++;
    if ({done, err, busy, bus.s_ready} !== 4'b1000) begin
      errors++; $display("FAIL normal_status: done,err,busy,rdy got %b expected 1000", {done, err, busy, bus.s_ready});
    end
    checks++;
    if (words_written !== 16'd2) begin
      errors++; $display("FAIL normal_words: got %0d expected 2", words_written);
    end
    checks++;
    if (bus.imem_waddr !== 32'd1 || bus.imem_wdata !== 32'h00200593 || bus.imem_we !== 1'b0) begin
      errors++; $display("FAIL normal_hold: got we=%b %h@%0d expected we=0 00200593@1", bus.imem_we, bus.imem_wdata, bus.imem_waddr);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] stream[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    int         gaps[10]   = '{1, 0, 2, 0, 3, 1, 0, 2, 1, 3};
    clear_log();
    pulse_load();
    for (int i = 0; i < 10; i++) send_byte(stream[i], gaps[i]);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (wr_addr_q.size() !== 2) begin
      errors++; $display("FAIL bp_nwrites: got %0d expected 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_data_q[0] !== 32'h00100513 || wr_data_q[1] !== 32'h00200593 ||
          wr_addr_q[0] !== 32'd0 || wr_addr_q[1] !== 32'd1) begin
        errors++; $display("FAIL bp_data: got %h@%0d %h@%0d expected 00100513@0 00200593@1",
                           wr_data_q[0], wr_addr_q[0], wr_data_q[1], wr_addr_q[1]);
      end
    end
    checks++;
    if (acc_cnt !== 10) begin
      errors++; $display("FAIL bp_accepts: got %0d expected 10", acc_cnt);
    end
    checks++;
    if (rdy_in_wr !== 0) begin
      errors++; $display("FAIL bp_ready_in_write: got %0d cycles expected 0", rdy_in_wr);
    end
    checks++;
    if (done !== 1'b1 || words_written !== 16'd2) begin
      errors++; $display("FAIL bp_done: done=%b words=%0d expected 1/2", done, words_written);
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_load();
    checks++;
    if (done !== 1'b0 || words_written !== 16'd0) begin
      errors++; $display("FAIL zero_clear: done=%b words=%0d expected 0/0", done, words_written);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    bus.s_data  = 8'h5A;
    bus.s_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.s_valid = 1'b0;
    checks++;
    if ({done, err, busy} !== 3'b100) begin
      errors++; $display("FAIL zero_status: done,err,busy got %b expected 100", {done, err, busy});
    end
    checks++;
    if (wr_addr_q.size() !== 0) begin
      errors++; $display("FAIL zero_writes: got %0d expected 0", wr_addr_q.size());
    end
    checks++;
    if (acc_cnt !== 2) begin
      errors++; $display("FAIL zero_accepts: got %0d expected 2", acc_cnt);
    end
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_load();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({err, done, busy, bus.s_ready} !== 4'b1000) begin
      errors++; $display("FAIL over_status: err,done,busy,rdy got %b expected 1000", {err, done, busy, bus.s_ready});
    end
    checks++;
    if (wr_addr_q.size() !== 0 || words_written !== 16'd0) begin
      errors++; $display("FAIL over_writes: got %0d writes words=%0d expected 0/0", wr_addr_q.size(), words_written);
    end
    // Exactly DEPTH is legal: loader must enter BYTES.
    pulse_load();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    checks++;
    if ({err, done, busy, bus.s_ready} !== 4'b0011) begin
      errors++; $display("FAIL depth_accepted: err,done,busy,rdy got %b expected 0011", {err, done, busy, bus.s_ready});
    end
    pulse_abort();
  endtask

  task automatic test_abort();
    logic [7:0] d[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] n[6] = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_log();
    pulse_load();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(d[i], 0);
    pulse_abort();
    @(posedge clk); #1;
    checks++;
    if (wr_addr_q.size() !== 1) begin
      errors++; $display("FAIL abort_nwrites: got %0d expected 1", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'd0 || wr_data_q[0] !== 32'h44332211) begin
        errors++; $display("FAIL abort_w0: got %h@%0d expected 44332211@0", wr_data_q[0], wr_addr_q[0]);
      end
    end
    checks++;
    if ({done, err, busy, bus.s_ready} !== 4'b0000) begin
      errors++; $display("FAIL abort_status: done,err,busy,rdy got %b expected 0000", {done, err, busy, bus.s_ready});
    end
    clear_log();
    pulse_load();
    for (int i = 0; i < 6; i++) send_byte(n[i], 0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (wr_addr_q.size() !== 1) begin
      errors++; $display("FAIL reload_nwrites: got %0d expected 1", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'd0 || wr_data_q[0] !== 32'hDDCCBBAA) begin
        errors++; $display("FAIL reload_w0: got %h@%0d expected DDCCBBAA@0", wr_data_q[0], wr_addr_q[0]);
      end
    end
    checks++;
    if (done !== 1'b1 || words_written !== 16'd1) begin
      errors++; $display("FAIL reload_done: done=%b words=%0d expected 1/1", done, words_written);
    end
    // Abort landing on the WRITE cycle must suppress that write.
    clear_log();
    pulse_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) send_byte(d[i], 0);
    pulse_abort();
    @(posedge clk); #1;
    checks++;
    if (wr_addr_q.size() !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_in_write: got %0d writes busy=%b expected 0/0", wr_addr_q.size(), busy);
    end
  endtask

  task automatic test_async_reset();
    clear_log();
    pulse_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.s_ready, bus.imem_we, busy, done, err} !== 5'b0 || words_written !== 16'd0) begin
      errors++; $display("FAIL areset_outputs: flags %b words=%0d expected 00000/0",
                         {bus.s_ready, bus.imem_we, busy, done, err}, words_written);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (wr_addr_q.size() !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL areset_nowrite: got %0d writes busy=%b expected 0/0", wr_addr_q.size(), busy);
    end
    pulse_load();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (wr_addr_q.size() !== 1 || wr_data_q[0] !== 32'hDDCCBBAA || wr_addr_q[0] !== 32'd0) begin
      errors++; $display("FAIL areset_reload: got %0d writes first %h@%0d expected 1 DDCCBBAA@0",
                         wr_addr_q.size(), wr_data_q[0], wr_addr_q[0]);
    end
    checks++;
    if (done !== 1'b1 || words_written !== 16'd1) begin
      errors++; $display("FAIL areset_done: done=%b words=%0d expected 1/1", done, words_written);
    end
  endtask

  initial begin
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    test_reset();
    test_normal();
    test_backpressure();
    test_zero_len();
    test_oversize();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
